// File: rtl/wb_stage_p_pkg.sv
// Shared encodings for the writeback stage: result select, load type and late-write arbiter state.
package wb_stage_p_pkg;

    typedef enum logic [1:0] {
        SEL_ALU  = 2'b00,
        SEL_MEM  = 2'b01,
        SEL_PC8  = 2'b10,
        SEL_ZERO = 2'b11
    } sel_e;

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_HS = 3'b001,
        LD_HU = 3'b010,
        LD_BS = 3'b011,
        LD_BU = 3'b100
    } ld_type_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_WAIT  = 2'b01,
        ARB_FORCE = 2'b10
    } arb_state_e;

endpackage

// File: rtl/wb_stage_p_load_ext.sv
// Load extraction: picks a big-endian byte/half lane from the low 32 bits of the load word
// and extends it to DATA_W; purely combinational, no flow control.
module load_ext
    import wb_stage_p_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem_out,
    input  logic [2:0]        ld_type,
    input  logic [1:0]        ld_off,
    output logic [DATA_W-1:0] ld_data
);

    logic [31:0] w_word;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    always_comb begin
        w_word = mem_out[31:0];
        // Lane 0 is the most significant byte of the word.
        w_half = ld_off[1] ? w_word[15:0] : w_word[31:16];
        case (ld_off)
            2'd0:    w_byte = w_word[31:24];
            2'd1:    w_byte = w_word[23:16];
            2'd2:    w_byte = w_word[15:8];
            default: w_byte = w_word[7:0];
        endcase
    end

    always_comb begin
        ld_data = DATA_W'(w_word);
        case (ld_type_e'(ld_type))
            LD_HS:   ld_data = {{(DATA_W-16){w_half[15]}}, w_half};
            LD_HU:   ld_data = {{(DATA_W-16){1'b0}}, w_half};
            LD_BS:   ld_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LD_BU:   ld_data = {{(DATA_W-8){1'b0}}, w_byte};
            default: ld_data = DATA_W'(w_word);
        endcase
    end

endmodule

// File: rtl/wb_stage_p.sv
// Writeback stage: an accepted request drives the rf_* write port one cycle later (1-cycle latency).
// Late multi-cycle writes take idle slots; after MAX_WAIT refusals in_ready drops for one forced slot.
module wb_stage_p
    import wb_stage_p_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RA_W     = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_out,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [1:0]        sel,
    input  logic [2:0]        ld_type,
    input  logic [1:0]        ld_off,
    input  logic              reg_we,
    input  logic [RA_W-1:0]   dst,
    input  logic              late_valid,
    output logic              late_ready,
    input  logic [RA_W-1:0]   late_dst,
    input  logic [DATA_W-1:0] late_data,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam int              CNT_W      = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WAIT);
    localparam bit              LATE_FIRST = (MAX_WAIT == 0);

    arb_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic              w_in_ready, w_late_ready, w_pipe_acc;
    logic [DATA_W-1:0] w_ld_data, w_sel_data;
    logic              r_rf_we;
    logic [RA_W-1:0]   r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .mem_out (mem_out),
        .ld_type (ld_type),
        .ld_off  (ld_off),
        .ld_data (w_ld_data)
    );

    always_comb begin
        w_sel_data = '0;
        case (sel_e'(sel))
            SEL_ALU: w_sel_data = alu_out;
            SEL_MEM: w_sel_data = w_ld_data;
            SEL_PC8: w_sel_data = pc_plus4 + DATA_W'(4);
            default: w_sel_data = '0;
        endcase
    end

    // The entry always retires in the cycle it is presented, so only FORCE (or reset) blocks the pipe.
    assign w_in_ready = rst_n && (r_state != ARB_FORCE) && !(LATE_FIRST && late_valid);
    assign w_pipe_acc = in_valid && w_in_ready;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt  = ARB_IDLE;
        w_cnt_nxt    = '0;
        w_late_ready = 1'b0;
        if (r_state == ARB_FORCE) begin
            w_late_ready = late_valid;
        end else if (late_valid) begin
            if (!w_pipe_acc) begin
                w_late_ready = 1'b1;
            end else begin
                w_cnt_nxt   = w_cnt_inc;
                w_state_nxt = (w_cnt_inc == CNT_MAX) ? ARB_FORCE : ARB_WAIT;
            end
        end
        w_late_ready = w_late_ready && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_cnt      <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_pipe_acc) begin
                r_rf_we    <= reg_we && (dst != '0);
                r_rf_waddr <= dst;
                r_rf_wdata <= w_sel_data;
            end else if (w_late_ready) begin
                r_rf_we    <= (late_dst != '0);
                r_rf_waddr <= late_dst;
                r_rf_wdata <= late_data;
            end else begin
                r_rf_we <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign late_ready = w_late_ready;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;

endmodule

// File: tb/tb_wb_stage_p.sv
// Bench for wb_stage_p: directed corner cases plus randomized traffic against a refusal-count model.
module tb_wb_stage_p;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] alu_out, mem_out, pc_plus4;
    logic [1:0]  sel;
    logic [2:0]  ld_type;
    logic [1:0]  ld_off;
    logic        reg_we;
    logic [4:0]  dst;
    logic        late_valid, late_ready;
    logic [4:0]  late_dst;
    logic [31:0] late_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_chk  = 0;
    int n_pass = 0;

    int          m_refused;
    logic        m_late_acc;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        s_in_ready, s_late_ready;

    wb_stage_p #(.DATA_W(32), .RA_W(5), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_out    (alu_out),
        .mem_out    (mem_out),
        .pc_plus4   (pc_plus4),
        .sel        (sel),
        .ld_type    (ld_type),
        .ld_off     (ld_off),
        .reg_we     (reg_we),
        .dst        (dst),
        .late_valid (late_valid),
        .late_ready (late_ready),
        .late_dst   (late_dst),
        .late_data  (late_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] ref_wdata(input logic [1:0] s, input logic [31:0] alu,
                                              input logic [31:0] mem, input logic [31:0] pc,
                                              input logic [2:0] ldt, input logic [1:0] off);
        int unsigned b, h;
        int          sh_b, sh_h;
        logic [31:0] r;
        sh_b = 24 - 8 * int'(off);
        sh_h = off[1] ? 0 : 16;
        b = (mem >> sh_b) & 32'hFF;
        h = (mem >> sh_h) & 32'hFFFF;
        case (s)
            2'd0: r = alu;
            2'd1: begin
                case (ldt)
                    3'd1:    r = (h >= 32768) ? (h | 32'hFFFF0000) : h;
                    3'd2:    r = h;
                    3'd3:    r = (b >= 128) ? (b | 32'hFFFFFF00) : b;
                    3'd4:    r = b;
                    default: r = mem;
                endcase
            end
            2'd2:    r = pc + 32'd4;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Called at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic step();
        logic exp_ir, exp_lr, pacc;
        #2;
        exp_ir = (m_refused < MAX_WAIT);
        pacc   = in_valid && exp_ir;
        exp_lr = late_valid && !pacc;
        s_in_ready   = in_ready;
        s_late_ready = late_ready;
        check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
        check_eq("late_ready", 32'(late_ready), 32'(exp_lr));
        if (pacc) begin
            e_we   = reg_we && (dst != 5'd0);
            e_addr = dst;
            e_data = ref_wdata(sel, alu_out, mem_out, pc_plus4, ld_type, ld_off);
        end else if (exp_lr) begin
            e_we   = (late_dst != 5'd0);
            e_addr = late_dst;
            e_data = late_data;
        end else begin
            e_we = 1'b0;
        end
        if (!late_valid || exp_lr) m_refused = 0;
        else if (m_refused < MAX_WAIT) m_refused = m_refused + 1;
        m_late_acc = exp_lr;
        @(posedge clk);
        #1;
        check_eq("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            check_eq("rf_waddr", 32'(rf_waddr), 32'(e_addr));
            check_eq("rf_wdata", rf_wdata, e_data);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_we"}, 32'(rf_we), 32'd0);
        check_eq({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
        check_eq({tag, "_wdata"}, rf_wdata, 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_late_ready"}, 32'(late_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; late_valid = 1'b1;
        alu_out = 32'h1111_2222; mem_out = 32'h3333_4444; pc_plus4 = 32'h100;
        sel = 2'd0; ld_type = 3'd0; ld_off = 2'd0; reg_we = 1'b1; dst = 5'd4;
        late_dst = 5'd6; late_data = 32'h5555_6666;
        m_refused = 0; m_late_acc = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
        #1;
        check_all_zero("rst0");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_held");
        rst_n = 1'b1; in_valid = 1'b0; late_valid = 1'b0;
        step();

        // Signed / unsigned byte loads
        in_valid = 1'b1; sel = 2'd1; mem_out = 32'h8899AABB; ld_type = 3'd3; ld_off = 2'd2;
        reg_we = 1'b1; dst = 5'd3;
        step();
        check_eq("lb_signed", rf_wdata, 32'hFFFFFFAA);
        ld_type = 3'd4;
        step();
        check_eq("lb_unsigned", rf_wdata, 32'h000000AA);

        // PC+8 wraps
        sel = 2'd2; pc_plus4 = 32'hFFFFFFFC;
        step();
        check_eq("pc8_wrap_we", 32'(rf_we), 32'd1);
        check_eq("pc8_wrap", rf_wdata, 32'h0);

        // Writes to r0 are suppressed
        sel = 2'd0; dst = 5'd0;
        step();
        check_eq("dst0_we", 32'(rf_we), 32'd0);
        in_valid = 1'b0; late_valid = 1'b1; late_dst = 5'd0; late_data = 32'hDEAD_BEEF;
        step();
        check_eq("late0_rdy", 32'(s_late_ready), 32'd1);
        check_eq("late0_we", 32'(rf_we), 32'd0);

        // Starvation: forced slot in cycle 5, pipeline resumes after
        in_valid = 1'b1; late_valid = 1'b1; late_dst = 5'd7; late_data = 32'h1234_5678;
        dst = 5'd5; sel = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            alu_out = $urandom;
            step();
            check_eq("force_in_ready", 32'(s_in_ready), 32'(k != 5));
        end
        check_eq("force_waddr", 32'(rf_waddr), 32'd7);
        check_eq("force_wdata", rf_wdata, 32'h1234_5678);
        late_valid = 1'b0; alu_out = 32'hCAFE_0001;
        step();
        check_eq("resume_we", 32'(rf_we), 32'd1);
        check_eq("resume_wdata", rf_wdata, 32'hCAFE_0001);

        // Reset while an entry is held and a late write waits
        in_valid = 1'b1; late_valid = 1'b1; dst = 5'd9; alu_out = 32'hA5A5_A5A5;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        check_eq("midrst_edge_we", 32'(rf_we), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0; late_valid = 1'b0;
        m_refused = 0; m_late_acc = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            if (late_valid && !m_late_acc) late_valid = ($urandom_range(0, 9) != 0);
            else                           late_valid = ($urandom_range(0, 3) == 0);
            sel      = 2'($urandom_range(0, 3));
            ld_type  = 3'($urandom_range(0, 7));
            ld_off   = 2'($urandom_range(0, 3));
            alu_out  = $urandom;
            mem_out  = $urandom;
            pc_plus4 = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
            reg_we   = ($urandom_range(0, 9) != 0);
            dst      = 5'($urandom_range(0, 31));
            late_dst = 5'($urandom_range(0, 31));
            late_data = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage_p.md
WB_STAGE_P -- requirements
Module: wb_stage_p

Interface
REQ-001 Parameter DATA_W, default 32: datapath width, multiple of 16, at least 32.
REQ-002 Parameter RA_W, default 5: register-address width.
REQ-003 Parameter MAX_WAIT, default 4: maximum number of cycles a pending late write may be refused before it is forced.
REQ-004 Port list:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  writeback request from the MEM stage.
- in_ready  out  1  stage accepts the request this cycle.
- alu_out  in  DATA_W  ALU result.
- mem_out  in  DATA_W  raw load word.
- pc_plus4  in  DATA_W  instruction PC+4.
- sel  in  2  source select: 00 ALU, 01 MEM, 10 PC+8, 11 zero.
- ld_type  in  3  load type: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; others treated as word.
- ld_off  in  2  byte offset of the load address.
- reg_we  in  1  instruction writes the register file.
- dst  in  RA_W  destination register.
- late_valid  in  1  late write request from the multi-cycle unit.
- late_ready  out  1  late write accepted this cycle.
- late_dst  in  RA_W  late write destination.
- late_data  in  DATA_W  late write data.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RA_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.

Function
REQ-005 A pipeline request is accepted on a rising edge when in_valid and in_ready are both high; it is captured into a one-entry writeback register.
REQ-006 in_ready is high when the writeback register is empty, or when its entry retires this cycle, and the arbiter is not in FORCE.
REQ-007 Result selection: ALU gives alu_out; MEM gives the extracted load; PC+8 gives pc_plus4 + 4 modulo 2^DATA_W; 11 gives 0.
REQ-008 Load extraction, big-endian lane order:
- half: bytes at offset {ld_off[1],0}, i.e. off 0 selects mem_out[31:16].
- byte: bytes at offset ld_off.
- sign or zero extension to DATA_W as ld_type specifies.
- When DATA_W > 32, only the low 32 bits of mem_out are used.
REQ-009 Extraction and selection complete before capture; the register stores the final write data.
REQ-010 Outputs are registered. A request accepted on edge N drives rf_we/rf_waddr/rf_wdata during cycle N+1. The entry retires in that same cycle.
REQ-011 rf_we is 0 whenever the entry has reg_we=0 or a destination of 0. The same rule applies to late writes with late_dst = 0, which are still acknowledged.
REQ-012 Arbiter states:
- IDLE: no late write waiting.
- WAIT: late_valid high and refused; the wait counter increments.
- FORCE: counter reached MAX_WAIT.
REQ-013 IDLE/WAIT: if no pipeline entry is captured on this edge, the late write is registered into the output slot and late_ready is high; the next state is IDLE. Otherwise the next state is WAIT.
REQ-014 FORCE: in_ready=0, the late write takes the next output slot, the counter clears, and the next state is IDLE.
REQ-015 Simultaneous events: a pipeline request and a late request in the same cycle with the arbiter not in FORCE resolve to the pipeline.
REQ-016 late_valid dropping while in WAIT returns the arbiter to IDLE and clears the counter.
REQ-017 The counter saturates at MAX_WAIT. MAX_WAIT=0 means a late write always wins the next slot.

Reset
REQ-018 While rst_n is low: rf_we=0, rf_waddr=0, rf_wdata=0, writeback register empty, arbiter in IDLE, counter 0, in_ready=0, late_ready=0.
REQ-019 Reset asserted mid-operation discards the held entry and any pending late write with no register-file write. in_ready rises in the first cycle after rst_n deasserts.

Structure
REQ-020 Select encodings, ld_type encodings and arbiter state encodings live in the shared header.
REQ-021 Load extraction is a separate combinational sub-module, load_ext, parameterised by DATA_W.

Verification
REQ-022 Bench scenarios:
- Load, mem_out=0x8899AABB, ld_type=011, off=2 -> rf_wdata=0xFFFFFFAA one cycle after accept. Same with ld_type=100 -> 0x000000AA.
- sel=10, pc_plus4=0xFFFFFFFC -> rf_wdata=0x00000000 (wrap).
- dst=0, reg_we=1 -> rf_we=0. late_dst=0 -> late_ready=1, rf_we=0.
- late_valid held high under continuous in_valid with MAX_WAIT=4 -> in_ready low in cycle 5, late write appears on the port the following cycle, then pipeline resumes.
- rst_n pulsed low during WAIT with an entry held -> no rf_we pulse; all outputs return to 0 asynchronously.
